// File: rtl/mem_stage.sv
// Memory stage of the dual-issue pipeline: waits on the slot-0 dcache response,
// aligns/extends load data, forwards both slots to dispatch and registers them for wb.
module mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pause,
  input  logic                  s0_valid,
  input  logic                  s0_reg_we,
  input  logic [REG_ADDR_W-1:0] s0_waddr,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic                  s0_is_load,
  input  logic [2:0]            s0_load_type,
  input  logic [1:0]            s0_addr_lo,
  input  logic                  s1_valid,
  input  logic                  s1_reg_we,
  input  logic [REG_ADDR_W-1:0] s1_waddr,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic                  dc_rvalid,
  input  logic [DATA_W-1:0]     dc_rdata,
  output logic                  pause_mem,
  output logic                  pf0_we,
  output logic [REG_ADDR_W-1:0] pf0_waddr,
  output logic [DATA_W-1:0]     pf0_wdata,
  output logic                  pf0_pending,
  output logic                  pf1_we,
  output logic [REG_ADDR_W-1:0] pf1_waddr,
  output logic [DATA_W-1:0]     pf1_wdata,
  output logic                  wb0_valid,
  output logic                  wb0_we,
  output logic [REG_ADDR_W-1:0] wb0_waddr,
  output logic [DATA_W-1:0]     wb0_wdata,
  output logic                  wb1_valid,
  output logic                  wb1_we,
  output logic [REG_ADDR_W-1:0] wb1_waddr,
  output logic [DATA_W-1:0]     wb1_wdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_ld;
  logic                    w_ld_avail;
  logic                    w_pause_mem;
  logic                    w_buf_load;
  logic                    w_outstanding;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_W-1:0]       w_aligned;
  logic [DATA_W-1:0]       w_s0_result;
  logic [DATA_W-1:0]       r_ld_buf;
  logic                    r_wb0_valid;
  logic                    r_wb0_we;
  logic [REG_ADDR_W-1:0]   r_wb0_waddr;
  logic [DATA_W-1:0]       r_wb0_wdata;
  logic                    r_wb1_valid;
  logic                    r_wb1_we;
  logic [REG_ADDR_W-1:0]   r_wb1_waddr;
  logic [DATA_W-1:0]       r_wb1_wdata;

  assign w_ld = s0_valid & s0_is_load;

  // NOTE: every variable is assigned on every path through an always_comb, so no latch is inferred.
  always_comb begin
    w_byte    = dc_rdata[7:0];
    w_half    = s0_addr_lo[1] ? dc_rdata[31:16] : dc_rdata[15:0];
    w_aligned = dc_rdata;
    unique case (s0_addr_lo)
      2'd0:    w_byte = dc_rdata[7:0];
      2'd1:    w_byte = dc_rdata[15:8];
      2'd2:    w_byte = dc_rdata[23:16];
      default: w_byte = dc_rdata[31:24];
    endcase
    case (s0_load_type)
      3'b000:  w_aligned = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b001:  w_aligned = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_aligned = {{(DATA_W-8){1'b0}}, w_byte};
      3'b101:  w_aligned = {{(DATA_W-16){1'b0}}, w_half};
      default: w_aligned = dc_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_avail    = 1'b0;
    w_pause_mem   = 1'b0;
    w_buf_load    = 1'b0;
    w_outstanding = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ld) begin
          if (dc_rvalid) begin
            w_ld_avail = 1'b1;
            if (pause) begin
              w_buf_load  = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_pause_mem   = 1'b1;
            w_outstanding = 1'b1;
            w_state_nxt   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dc_rvalid) begin
          w_ld_avail  = 1'b1;
          w_buf_load  = pause;
          w_state_nxt = pause ? ST_HOLD : ST_IDLE;
        end else begin
          w_pause_mem   = 1'b1;
          w_outstanding = 1'b1;
        end
      end
      ST_HOLD: begin
        w_ld_avail = 1'b1;
        if (!pause) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        w_pause_mem = w_ld;
        if (dc_rvalid) w_state_nxt = ST_IDLE;
        else           w_outstanding = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A flush only needs to drain when a response is still owed by the dcache.
    if (flush) w_state_nxt = w_outstanding ? ST_DRAIN : ST_IDLE;
  end

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the load buffer is pure data qualified by r_state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_buf_load) r_ld_buf <= w_aligned;
  end

  always_comb begin
    w_s0_result = s0_wdata;
    if (w_ld) w_s0_result = (r_state == ST_HOLD) ? r_ld_buf : w_aligned;
  end

  assign pause_mem   = w_pause_mem;
  assign pf0_we      = s0_valid & s0_reg_we;
  assign pf0_waddr   = s0_waddr;
  assign pf0_wdata   = w_s0_result;
  assign pf0_pending = w_ld & ~w_ld_avail;
  assign pf1_we      = s1_valid & s1_reg_we;
  assign pf1_waddr   = s1_waddr;
  assign pf1_wdata   = s1_wdata;

  // Both slots share one enable so slot 1 can never retire ahead of slot 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wb0_valid <= 1'b0;
      r_wb0_we    <= 1'b0;
      r_wb0_waddr <= '0;
      r_wb0_wdata <= '0;
      r_wb1_valid <= 1'b0;
      r_wb1_we    <= 1'b0;
      r_wb1_waddr <= '0;
      r_wb1_wdata <= '0;
    end else if (w_pause_mem) begin
      r_wb0_valid <= 1'b0;
      r_wb0_we    <= 1'b0;
      r_wb1_valid <= 1'b0;
      r_wb1_we    <= 1'b0;
    end else if (!pause) begin
      r_wb0_valid <= s0_valid;
      r_wb0_we    <= s0_valid & s0_reg_we;
      r_wb0_waddr <= s0_waddr;
      r_wb0_wdata <= w_s0_result;
      r_wb1_valid <= s1_valid;
      r_wb1_we    <= s1_valid & s1_reg_we;
      r_wb1_waddr <= s1_waddr;
      r_wb1_wdata <= s1_wdata;
    end
  end

  assign wb0_valid = r_wb0_valid;
  assign wb0_we    = r_wb0_we;
  assign wb0_waddr = r_wb0_waddr;
  assign wb0_wdata = r_wb0_wdata;
  assign wb1_valid = r_wb1_valid;
  assign wb1_we    = r_wb1_we;
  assign wb1_waddr = r_wb1_waddr;
  assign wb1_wdata = r_wb1_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: the bench plays ctrl and an in-order dcache, and checks the DUT
// every cycle against a transaction-level model of which instruction retires with what data.
module tb_mem_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, pause;
  logic          s0_valid, s0_reg_we, s0_is_load;
  logic [AW-1:0] s0_waddr;
  logic [DW-1:0] s0_wdata;
  logic [2:0]    s0_load_type;
  logic [1:0]    s0_addr_lo;
  logic          s1_valid, s1_reg_we;
  logic [AW-1:0] s1_waddr;
  logic [DW-1:0] s1_wdata;
  logic          dc_rvalid;
  logic [DW-1:0] dc_rdata;
  logic          pause_mem, pf0_we, pf0_pending, pf1_we;
  logic [AW-1:0] pf0_waddr, pf1_waddr;
  logic [DW-1:0] pf0_wdata, pf1_wdata;
  logic          wb0_valid, wb0_we, wb1_valid, wb1_we;
  logic [AW-1:0] wb0_waddr, wb1_waddr;
  logic [DW-1:0] wb0_wdata, wb1_wdata;

  mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .s0_valid(s0_valid), .s0_reg_we(s0_reg_we), .s0_waddr(s0_waddr), .s0_wdata(s0_wdata),
    .s0_is_load(s0_is_load), .s0_load_type(s0_load_type), .s0_addr_lo(s0_addr_lo),
    .s1_valid(s1_valid), .s1_reg_we(s1_reg_we), .s1_waddr(s1_waddr), .s1_wdata(s1_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .pause_mem(pause_mem),
    .pf0_we(pf0_we), .pf0_waddr(pf0_waddr), .pf0_wdata(pf0_wdata), .pf0_pending(pf0_pending),
    .pf1_we(pf1_we), .pf1_waddr(pf1_waddr), .pf1_wdata(pf1_wdata),
    .wb0_valid(wb0_valid), .wb0_we(wb0_we), .wb0_waddr(wb0_waddr), .wb0_wdata(wb0_wdata),
    .wb1_valid(wb1_valid), .wb1_we(wb1_we), .wb1_waddr(wb1_waddr), .wb1_wdata(wb1_wdata)
  );

  typedef struct {
    logic        v0, we0, ld;
    logic [4:0]  wa0;
    logic [31:0] wd0, rdata;
    logic [2:0]  lt;
    logic [1:0]  al;
    int          lat;
    logic        v1, we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    bit          directed;
    logic [7:0]  pz;
    int          flush_at;
    bit          lit_en, lit1_en;
    logic [31:0] lit, lit1;
    int          pm_cycles;
  } instr_t;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          stale;
  } rsp_t;

  instr_t      dir_q[$];
  rsp_t        rq[$];
  instr_t      cur;
  bit          have_cur, cur_new, cur_dlv, prev_rvalid, cmp_en;
  int          age, pm_seen, cyc;
  int          total = 0;
  int          bad = 0;
  logic        e_pm, ext_pause;
  logic [31:0] e_res0;
  logic        m_v0, m_we0, m_v1, m_we1;
  logic [4:0]  m_wa0, m_wa1;
  logic [31:0] m_wd0, m_wd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference alignment written from the load-type table with shifts and masks.
  function automatic logic [31:0] align_ref(input logic [2:0] t, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (t)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic instr_t blank();
    instr_t r;
    r.v0 = 0; r.we0 = 0; r.ld = 0; r.wa0 = '0; r.wd0 = '0; r.rdata = '0; r.lt = '0; r.al = '0;
    r.lat = 0; r.v1 = 0; r.we1 = 0; r.wa1 = '0; r.wd1 = '0; r.directed = 0; r.pz = '0;
    r.flush_at = -1; r.lit_en = 0; r.lit1_en = 0; r.lit = '0; r.lit1 = '0; r.pm_cycles = -1;
    return r;
  endfunction

  function automatic instr_t mk_load(input logic [2:0] lt, input logic [1:0] al,
                                     input logic [31:0] rd, input int lat,
                                     input logic [31:0] lit, input int pm);
    instr_t r;
    r = blank();
    r.v0 = 1; r.we0 = 1; r.wa0 = 5'd9; r.ld = 1; r.lt = lt; r.al = al; r.rdata = rd;
    r.lat = lat; r.directed = 1; r.lit_en = 1; r.lit = lit; r.pm_cycles = pm;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r = blank();
    r.v0    = ($urandom_range(0, 9) != 0);
    r.we0   = ($urandom_range(0, 5) != 0);
    r.wa0   = 5'($urandom);
    r.wd0   = $urandom;
    r.ld    = r.v0 && ($urandom_range(0, 1) == 1);
    r.lt    = 3'($urandom);
    r.al    = 2'($urandom);
    r.rdata = $urandom;
    r.lat   = $urandom_range(0, 4);
    r.v1    = ($urandom_range(0, 4) != 0);
    r.we1   = ($urandom_range(0, 5) != 0);
    r.wa1   = 5'($urandom);
    r.wd1   = $urandom;
    return r;
  endfunction

  task automatic new_instr();
    rsp_t r;
    if (dir_q.size() > 0) cur = dir_q.pop_front();
    else                  cur = rand_instr();
    have_cur = 1; cur_new = 1; cur_dlv = 0; age = 0; pm_seen = 0;
    if (cur.ld) begin
      r.data = cur.rdata; r.due = cyc + cur.lat; r.stale = 1'b0;
      rq.push_back(r);
    end
  endtask

  // Single compare process: every cycle, after the negedge stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check("pause_mem",   32'(pause_mem),   32'(e_pm));
      check("pf0_pending", 32'(pf0_pending), 32'(e_pm));
      check("pf0_we",      32'(pf0_we),      32'(cur.v0 & cur.we0));
      check("pf0_waddr",   32'(pf0_waddr),   32'(cur.wa0));
      if (!e_pm) check("pf0_wdata", pf0_wdata, e_res0);
      check("pf1_we",      32'(pf1_we),      32'(cur.v1 & cur.we1));
      check("pf1_waddr",   32'(pf1_waddr),   32'(cur.wa1));
      check("pf1_wdata",   pf1_wdata,        cur.wd1);
      check("wb0_valid",   32'(wb0_valid),   32'(m_v0));
      check("wb0_we",      32'(wb0_we),      32'(m_we0));
      if (m_v0) begin
        check("wb0_waddr", 32'(wb0_waddr),   32'(m_wa0));
        check("wb0_wdata", wb0_wdata,        m_wd0);
      end
      check("wb1_valid",   32'(wb1_valid),   32'(m_v1));
      check("wb1_we",      32'(wb1_we),      32'(m_we1));
      if (m_v1) begin
        check("wb1_waddr", 32'(wb1_waddr),   32'(m_wa1));
        check("wb1_wdata", wb1_wdata,        m_wd1);
      end
    end
  end

  initial begin
    bit     fl_ok, accepted;
    instr_t t;

    cmp_en = 0; cyc = 0; have_cur = 0; prev_rvalid = 0; age = 0; pm_seen = 0;
    cur = blank(); e_pm = 0; e_res0 = '0; ext_pause = 0;
    m_v0 = 0; m_we0 = 0; m_wa0 = '0; m_wd0 = '0; m_v1 = 0; m_we1 = 0; m_wa1 = '0; m_wd1 = '0;

    // Live-looking ALU traffic during reset must not reach wb.
    rst = 1; flush = 0; pause = 0; dc_rvalid = 0; dc_rdata = 32'h1111_2222;
    s0_valid = 1; s0_reg_we = 1; s0_waddr = 5'd3; s0_wdata = 32'hABCD_0001; s0_is_load = 0;
    s0_load_type = 3'b010; s0_addr_lo = 2'd0;
    s1_valid = 1; s1_reg_we = 1; s1_waddr = 5'd4; s1_wdata = 32'hABCD_0002;
    repeat (3) @(negedge clk);
    check("rst_wb0_valid", 32'(wb0_valid), 32'd0);
    check("rst_wb0_we",    32'(wb0_we),    32'd0);
    check("rst_wb1_valid", 32'(wb1_valid), 32'd0);
    check("rst_wb0_wdata", wb0_wdata,      32'd0);
    check("rst_pause_mem", 32'(pause_mem), 32'd0);
    rst = 0; s0_valid = 0; s1_valid = 0; s0_reg_we = 0; s1_reg_we = 0;

    // Directed scenarios, then random traffic through the same driver.
    dir_q.push_back(mk_load(3'b010, 2'd0, 32'h8765_4321, 0, 32'h8765_4321, 0));
    dir_q.push_back(mk_load(3'b000, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80, 3));
    dir_q.push_back(mk_load(3'b101, 2'd2, 32'h8000_1234, 1, 32'h0000_8000, 1));
    dir_q.push_back(mk_load(3'b001, 2'd2, 32'h8000_1234, 2, 32'hFFFF_8000, 2));
    t = mk_load(3'b010, 2'd0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 2);
    t.pz = 8'b0000_1100;
    dir_q.push_back(t);
    t = mk_load(3'b010, 2'd0, 32'h0000_DEAD, 5, 32'd0, -1);
    t.lit_en = 0; t.flush_at = 2;
    dir_q.push_back(t);
    dir_q.push_back(mk_load(3'b010, 2'd0, 32'h0000_0055, 0, 32'h0000_0055, -1));
    t = mk_load(3'b010, 2'd0, 32'h1234_5678, 3, 32'h1234_5678, 3);
    t.v1 = 1; t.we1 = 1; t.wa1 = 5'd7; t.wd1 = 32'h10; t.lit1_en = 1; t.lit1 = 32'h10;
    dir_q.push_back(t);

    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      if (!have_cur) new_instr();
      dc_rvalid = 1'b0;
      dc_rdata  = $urandom;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        dc_rvalid = 1'b1;
        dc_rdata  = rq[0].data;
        if (!rq[0].stale) cur_dlv = 1'b1;
        rq.delete(0);
      end
      e_pm  = cur.ld && !cur_dlv;
      // Flush only while the sole outstanding request is the current load's, or nothing is owed.
      fl_ok = (cur.ld && !cur_dlv && !cur_new && !dc_rvalid && !prev_rvalid && rq.size() == 1) ||
              (!cur.ld && rq.size() == 0);
      if (cur.directed) begin
        ext_pause = (age < 8) ? cur.pz[age] : 1'b0;
        flush     = fl_ok && (age == cur.flush_at);
      end else begin
        ext_pause = ($urandom_range(0, 4) == 0);
        flush     = fl_ok && ($urandom_range(0, 11) == 0);
      end
      pause        = ext_pause | e_pm;
      s0_valid     = cur.v0;  s0_reg_we  = cur.we0; s0_waddr   = cur.wa0; s0_wdata = cur.wd0;
      s0_is_load   = cur.ld;  s0_load_type = cur.lt; s0_addr_lo = cur.al;
      s1_valid     = cur.v1;  s1_reg_we  = cur.we1; s1_waddr   = cur.wa1; s1_wdata = cur.wd1;
      e_res0       = cur.ld ? align_ref(cur.lt, cur.al, cur.rdata) : cur.wd0;
      cmp_en       = 1;

      #3;
      if (pause_mem) pm_seen++;
      if (flush) begin
        m_v0 = 0; m_we0 = 0; m_wa0 = '0; m_wd0 = '0;
        m_v1 = 0; m_we1 = 0; m_wa1 = '0; m_wd1 = '0;
      end else if (e_pm) begin
        m_v0 = 0; m_we0 = 0; m_v1 = 0; m_we1 = 0;
      end else if (!pause) begin
        m_v0 = cur.v0; m_we0 = cur.v0 & cur.we0; m_wa0 = cur.wa0; m_wd0 = e_res0;
        m_v1 = cur.v1; m_we1 = cur.v1 & cur.we1; m_wa1 = cur.wa1; m_wd1 = cur.wd1;
      end
      prev_rvalid = dc_rvalid;
      accepted    = !flush && !pause;
      if (flush) begin
        if (cur.ld && !cur_dlv) rq[rq.size()-1].stale = 1'b1;
        have_cur = 0;
      end else if (accepted) begin
        have_cur = 0;
      end
      cur_new = 0;
      age++;
      cyc++;
      if (accepted && cur.directed) begin
        if (cur.pm_cycles >= 0) check("ld_stall_cycles", 32'(pm_seen), 32'(cur.pm_cycles));
        @(posedge clk);
        #1;
        if (cur.lit_en)  check("lit_wb0_wdata", wb0_wdata, cur.lit);
        if (cur.lit1_en) check("lit_wb1_wdata", wb1_wdata, cur.lit1);
      end
    end

    cmp_en = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
